pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 SHALL have ports: D_icode  in  4  icode in decode stage.
REQ-004 SHALL have ports: d_srcA, d_srcB  in  4 each  decode source register IDs (4'hF = RNONE).
REQ-005 SHALL have ports: E_icode  in  4  icode in execute stage.
REQ-006 SHALL have ports: E_dstM  in  4  execute-stage memory destination register.
REQ-007 SHALL have ports: e_Cnd  in  1  branch/cmov condition from execute.
REQ-008 SHALL have ports: set_cc  in  1  execute requests CC write; new_cc  in  3  candidate flags {ZF,SF,OF}.
REQ-009 SHALL have ports: m_stat, W_stat  in  2 each  memory/writeback status (AOK=0, HLT=1, ADR=2, INS=3).
REQ-010 SHALL have ports: cc  out  3  registered condition codes {ZF,SF,OF}, fed back to execute.
REQ-011 SHALL have ports: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  out  1 each  pipeline-register controls.
REQ-012 SHALL have ports: halted  out  1  processor stopped.

Function
REQ-013 SHALL update cc <= new_cc at the clock edge only when set_cc=1, E_icode=OPq (4'h6), m_stat=AOK, W_stat=AOK and state=RUN; otherwise cc holds.
REQ-014 SHALL detect load/use when E_icode in {MRMOVQ 4'h5, POPQ 4'hB}, E_dstM!=RNONE and E_dstM equals d_srcA or d_srcB; response F_stall=1, D_stall=1, E_bubble=1, same cycle (combinational).
REQ-015 SHALL detect mispredict when E_icode=JXX (4'h7) and e_Cnd=0; response D_bubble=1, E_bubble=1, same cycle.
REQ-016 SHALL sequence ret with 2-bit ret_cnt: cycle with D_icode=RET (4'h9) asserts F_stall=1, D_bubble=1 and loads ret_cnt=2; each cycle with ret_cnt!=0 asserts F_stall=1, D_bubble=1 and decrements; total 3 bubble cycles per ret.
REQ-017 SHALL, on load/use coinciding with D_icode=RET, assert D_stall not D_bubble and not load ret_cnt.
REQ-018 SHALL, on mispredict coinciding with D_icode=RET, bubble D and not load ret_cnt (wrong-path ret discarded).
REQ-019 SHALL never assert D_stall and D_bubble together; D_stall wins.
REQ-020 SHALL assert M_bubble=1 whenever m_stat!=AOK or W_stat!=AOK, and suppress CC writes in that cycle.
REQ-021 SHALL implement FSM RUN->HALT when W_stat!=AOK at a clock edge; HALT is absorbing until reset.
REQ-022 SHALL, in HALT, drive halted=1, F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0, and hold cc and ret_cnt.
REQ-023 SHALL assert W_stall=1 in the RUN cycle where W_stat!=AOK.
REQ-024 SHALL apply priority HALT > exception (REQ-020) > mispredict > load/use > ret.

Reset
REQ-025 SHALL, on clock edge with reset_n=0, set cc=3'b100, state=RUN, ret_cnt=0.
REQ-026 SHALL force all control outputs and halted to 0 while reset_n=0, regardless of inputs.
REQ-027 SHALL discard any in-progress ret sequence or HALT on reset mid-operation.

Structure
REQ-028 SHALL take icode constants, RNONE, stat codes, CC bit indices and FSM state encoding from shared package y86_pkg.
REQ-029 SHALL isolate the CC register (REQ-013 gating) in sub-module cc_reg; hazard logic and FSM stay in pipe_ctrl.

Verification
REQ-030 SHALL test: after reset, E_icode=6, set_cc=1, new_cc=3'b010, stats AOK -> cc=3'b010 next edge; same with m_stat=ADR -> cc stays 3'b100, M_bubble=1.
REQ-031 SHALL test: E_icode=5, E_dstM=4'h3, d_srcA=4'h3 -> F_stall=D_stall=E_bubble=1 one cycle; E_dstM=4'hF -> all 0.
REQ-032 SHALL test: D_icode=9 one cycle then nop -> F_stall=D_bubble=1 for exactly 3 cycles, then 0.
REQ-033 SHALL test: E_icode=7, e_Cnd=0, D_icode=9 simultaneously -> D_bubble=E_bubble=1, no subsequent ret bubbles.
REQ-034 SHALL test: W_stat=HLT one cycle -> W_stall=1, next cycle halted=1 with REQ-022 outputs persisting; reset_n=0 one edge -> halted=0, cc=3'b100.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 pipeline constants: icodes, register IDs, status codes, CC layout, FSM states.
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Condition-code bit positions inside the {ZF,SF,OF} vector
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  // Reset value: ZF set, SF and OF clear
  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/cc_reg.sv
// Condition-code register; writes only for an OPq in execute while the pipe runs exception-free.
module cc_reg
  import y86_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       set_cc,
  input  logic [3:0] E_icode,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  input  logic [2:0] new_cc,
  output logic [2:0] cc
);

  logic [2:0] cc_d;
  logic [2:0] cc_q;
  logic       wr_en;

  // Write-enable gating and next-value select
  always_comb begin
    wr_en = run && set_cc && (E_icode == I_OPQ) &&
            (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
    cc_d  = wr_en ? new_cc : cc_q;
  end

  // CC state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) cc_q <= CC_RESET;
    else          cc_q <= cc_d;
  end

  assign cc = cc_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: hazard detection, ret sequencing, RUN/HALT FSM, CC register.
module pipe_ctrl
  import y86_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic       set_cc,
  input  logic [2:0] new_cc,
  input  logic [1:0] m_stat,
  input  logic [1:0] W_stat,
  output logic [2:0] cc,
  output logic       F_stall,
  output logic       D_stall,
  output logic       D_bubble,
  output logic       E_bubble,
  output logic       M_bubble,
  output logic       W_stall,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [1:0] ret_cnt_q, ret_cnt_d;
  logic       exc, mispredict, load_use, ret_req;

  cc_reg u_cc_reg (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (state_q == ST_RUN),
    .set_cc  (set_cc),
    .E_icode (E_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .new_cc  (new_cc),
    .cc      (cc)
  );

  // Hazard classification, prioritised control outputs and next state
  always_comb begin
    F_stall   = 1'b0;
    D_stall   = 1'b0;
    D_bubble  = 1'b0;
    E_bubble  = 1'b0;
    M_bubble  = 1'b0;
    W_stall   = 1'b0;
    halted    = 1'b0;
    state_d   = state_q;
    ret_cnt_d = ret_cnt_q;

    exc        = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
    mispredict = (E_icode == I_JXX) && !e_Cnd;
    load_use   = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_req    = (D_icode == I_RET) || (ret_cnt_q != 2'd0);

    if (!reset_n) begin
      // outputs stay low; registers are cleared at the edge
    end else if (state_q == ST_HALT) begin
      halted   = 1'b1;
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      if (W_stat != STAT_AOK) state_d = ST_HALT;
      // Only the highest-priority condition acts; ret_cnt advances only when ret owns the cycle
      if (exc) begin
        M_bubble = 1'b1;
        W_stall  = (W_stat != STAT_AOK);
      end else if (mispredict) begin
        D_bubble = 1'b1;
        E_bubble = 1'b1;
      end else if (load_use) begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
      end else if (ret_req) begin
        F_stall   = 1'b1;
        D_bubble  = 1'b1;
        ret_cnt_d = (D_icode == I_RET) ? 2'd2 : ret_cnt_q - 2'd1;
      end
    end
  end

  // FSM state and ret counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized run against a reference model.
module tb_pipe_ctrl;

  logic       clock;
  logic       reset_n;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM;
  logic       e_Cnd, set_cc;
  logic [2:0] new_cc;
  logic [1:0] m_stat, W_stat;
  logic [2:0] cc;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [6:0] act;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [2:0] m_cc;
  bit         m_halt;
  int         m_ret;   // ret bubble cycles still owed after the RET cycle itself

  pipe_ctrl dut (
    .clock(clock), .reset_n(reset_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .set_cc(set_cc), .new_cc(new_cc),
    .m_stat(m_stat), .W_stat(W_stat), .cc(cc), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted)
  );

  assign act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,halted} from the rules
  function automatic logic [6:0] exp_outs();
    logic [6:0] r;
    r = 7'b0;
    if (!reset_n) return r;
    if (m_halt) return 7'b1101111;
    if (m_stat != 2'd0 || W_stat != 2'd0) begin
      r[2] = 1'b1;
      r[1] = (W_stat != 2'd0);
    end else if (E_icode == 4'h7 && !e_Cnd) begin
      r[4] = 1'b1; r[3] = 1'b1;
    end else if ((E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
                 (E_dstM == d_srcA || E_dstM == d_srcB)) begin
      r[6] = 1'b1; r[5] = 1'b1; r[3] = 1'b1;
    end else if (D_icode == 4'h9 || m_ret > 0) begin
      r[6] = 1'b1; r[4] = 1'b1;
    end
    return r;
  endfunction

  // Advance model by one clock edge with current inputs
  task automatic model_step();
    logic [6:0] o;
    o = exp_outs();
    if (!reset_n) begin
      m_cc = 3'b100; m_halt = 1'b0; m_ret = 0;
    end else if (!m_halt) begin
      if (set_cc && E_icode == 4'h6 && m_stat == 2'd0 && W_stat == 2'd0) m_cc = new_cc;
      if (o[6] && o[4]) m_ret = (D_icode == 4'h9) ? 2 : m_ret - 1;
      if (W_stat != 2'd0) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
    e_Cnd = 1'b1; set_cc = 1'b0; new_cc = 3'b000; m_stat = 2'd0; W_stat = 2'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; set_idle(); tick(); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2; d_srcB = 4'h0;
    e_Cnd = 1'b0; set_cc = 1'b1; new_cc = 3'b011; m_stat = 2'd2; W_stat = 2'd1;
    #1;
    total++;
    if (act !== 7'b0) begin bad++; $display("FAIL reset_outs: got %b expected %b", act, 7'b0); end
    tick();
    total++;
    if (cc !== 3'b100) begin bad++; $display("FAIL reset_cc: got %b expected %b", cc, 3'b100); end
    reset_n = 1'b1; set_idle(); #1;
    total++;
    if (act !== 7'b0) begin bad++; $display("FAIL reset_idle: got %b expected %b", act, 7'b0); end
  endtask

  task automatic test_cc();
    do_reset();
    E_icode = 4'h6; set_cc = 1'b1; new_cc = 3'b010; #1;
    tick();
    total++;
    if (cc !== 3'b010) begin bad++; $display("FAIL cc_write: got %b expected %b", cc, 3'b010); end
    do_reset();
    E_icode = 4'h6; set_cc = 1'b1; new_cc = 3'b010; m_stat = 2'd2; #1;
    total++;
    if (M_bubble !== 1'b1) begin bad++; $display("FAIL cc_exc_mbubble: got %b expected 1", M_bubble); end
    tick();
    total++;
    if (cc !== 3'b100) begin bad++; $display("FAIL cc_exc_hold: got %b expected %b", cc, 3'b100); end
    set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    total++;
    if (act !== 7'b1101000) begin bad++; $display("FAIL load_use: got %b expected %b", act, 7'b1101000); end
    tick();
    E_dstM = 4'hF; d_srcA = 4'hF; #1;
    total++;
    if (act !== 7'b0) begin bad++; $display("FAIL load_use_rnone: got %b expected %b", act, 7'b0); end
    // load/use with RET in decode: stall wins, no ret sequence afterwards
    E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; D_icode = 4'h9; #1;
    total++;
    if (act !== 7'b1101000) begin bad++; $display("FAIL load_use_ret: got %b expected %b", act, 7'b1101000); end
    tick();
    set_idle(); #1;
    total++;
    if (act !== 7'b0) begin bad++; $display("FAIL load_use_ret_after: got %b expected %b", act, 7'b0); end
  endtask

  task automatic test_ret();
    do_reset();
    D_icode = 4'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({F_stall, D_bubble} !== ((i < 3) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL ret_cycle%0d: got %b expected %b", i, {F_stall, D_bubble}, (i < 3) ? 2'b11 : 2'b00);
      end
      tick();
      D_icode = 4'h1;
    end
    // reset in mid-sequence discards remaining bubbles
    D_icode = 4'h9; tick();
    do_reset(); #1;
    total++;
    if (D_bubble !== 1'b0) begin bad++; $display("FAIL ret_reset_discard: got %b expected 0", D_bubble); end
  endtask

  task automatic test_mispredict_ret();
    do_reset();
    E_icode = 4'h7; e_Cnd = 1'b0; D_icode = 4'h9; #1;
    total++;
    if (act !== 7'b0011000) begin bad++; $display("FAIL mispredict_ret: got %b expected %b", act, 7'b0011000); end
    tick();
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({F_stall, D_bubble} !== 2'b00) begin
        bad++; $display("FAIL mispredict_no_ret%0d: got %b expected 00", i, {F_stall, D_bubble});
      end
      tick();
    end
  endtask

  task automatic test_halt();
    do_reset();
    W_stat = 2'd1; #1;
    total++;
    if ({W_stall, M_bubble, halted} !== 3'b110) begin
      bad++; $display("FAIL halt_entry: got %b expected 110", {W_stall, M_bubble, halted});
    end
    tick();
    set_idle(); E_icode = 4'h6; set_cc = 1'b1; new_cc = 3'b011; D_icode = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (act !== 7'b1101111) begin bad++; $display("FAIL halt_outs%0d: got %b expected %b", i, act, 7'b1101111); end
      tick();
      total++;
      if (cc !== 3'b100) begin bad++; $display("FAIL halt_cc%0d: got %b expected %b", i, cc, 3'b100); end
    end
    reset_n = 1'b0; #1;
    total++;
    if (act !== 7'b0) begin bad++; $display("FAIL halt_reset_outs: got %b expected %b", act, 7'b0); end
    tick();
    reset_n = 1'b1; set_idle(); #1;
    total++;
    if (halted !== 1'b0 || cc !== 3'b100) begin
      bad++; $display("FAIL halt_reset: got halted=%b cc=%b expected halted=0 cc=100", halted, cc);
    end
  endtask

  task automatic test_random();
    logic [3:0] icodes [7];
    logic [6:0] e;
    icodes = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h0};
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 39) != 0);
      D_icode = icodes[$urandom_range(0, 6)];
      E_icode = icodes[$urandom_range(0, 6)];
      d_srcA  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      d_srcB  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      E_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      e_Cnd   = 1'($urandom_range(0, 1));
      set_cc  = 1'($urandom_range(0, 1));
      new_cc  = 3'($urandom_range(0, 7));
      m_stat  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat  = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      #1;
      e = exp_outs();
      total++;
      if (act !== e) begin bad++; $display("FAIL rand_outs cyc%0d: got %b expected %b", n, act, e); end
      total++;
      if (cc !== m_cc) begin bad++; $display("FAIL rand_cc cyc%0d: got %b expected %b", n, cc, m_cc); end
      tick();
    end
  endtask

  initial begin
    m_cc = 3'b100; m_halt = 1'b0; m_ret = 0;
    reset_n = 1'b0; set_idle();
    @(posedge clock); #1;
    test_reset();
    test_cc();
    test_load_use();
    test_ret();
    test_mispredict_ret();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
